// File: rtl/lesson_controller.sv
// Lesson-mode sequencer: walks a song ROM, hints the expected key on Led and scores presses.
// Define LESSON_TIMEOUT_EN to skip a note (and count a mistake) after TIMEOUT_BEATS beats.
module lesson_controller #(
  parameter int unsigned ADDR_W        = 6,
  parameter int unsigned TIMEOUT_BEATS = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              QUARTER_BEAT,
  input  logic [7:0]        sw,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_note,
  output logic [3:0]        note,
  output logic [7:0]        Led,
  output logic [7:0]        mistakes,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0] EndCode = 4'd15;

  if (TIMEOUT_BEATS < 1 || TIMEOUT_BEATS > 255) begin : g_bad_timeout
    $error("TIMEOUT_BEATS must lie in 1..255");
  end

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StEval,
    StArm,
    StWaitKey,
    StHold,
    StRelease,
    StRest,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        expected_q, expected_d;
  logic [3:0]        note_q, note_d;
  logic [7:0]        led_q, led_d;
  logic [7:0]        mistakes_q, mistakes_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [3:0] pressed;
  logic       key_down;
  logic       rom_is_note;
  logic [7:0] rom_hint;
  logic [7:0] mistakes_inc;
  logic       last_addr;
  logic       timeout;
  logic       advance;

  // Later (higher) indices overwrite earlier ones, so the highest pressed key wins.
  always_comb begin
    pressed = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (sw[i]) pressed = 4'(8 - i);
    end
  end

  assign key_down     = |sw;
  assign rom_is_note  = (rom_note >= 4'd1) && (rom_note <= 4'd8);
  assign rom_hint     = rom_is_note ? (8'h80 >> (rom_note - 4'd1)) : 8'h00;
  assign mistakes_inc = (mistakes_q == 8'hFF) ? 8'hFF : mistakes_q + 8'd1;
  assign last_addr    = (addr_q == {ADDR_W{1'b1}});

`ifdef LESSON_TIMEOUT_EN
  logic [7:0] beat_q, beat_d;
  logic       counting;

  assign counting = (state_q == StWaitKey) || (state_q == StRelease);
  assign timeout  = counting && QUARTER_BEAT &&
                    (({1'b0, beat_q} + 9'd1) >= 9'(TIMEOUT_BEATS));

  // Held at zero in EVAL/ARM so every fresh WAIT_KEY starts from a clean count.
  always_comb begin
    beat_d = beat_q;
    if ((state_q == StEval) || (state_q == StArm)) begin
      beat_d = 8'd0;
    end else if (counting && QUARTER_BEAT) begin
      beat_d = beat_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      beat_q <= 8'd0;
    end else begin
      beat_q <= beat_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    expected_d = expected_q;
    note_d     = note_q;
    led_d      = led_q;
    mistakes_d = mistakes_q;
    advance    = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StIdle;
      end
      StFetch: begin
        state_d = StEval;
      end
      StEval: begin
        expected_d = rom_note;
        note_d     = 4'd0;
        if (rom_note == EndCode) begin
          state_d = StDone;
          led_d   = 8'h00;
        end else if (!rom_is_note) begin
          state_d = StRest;
          led_d   = 8'h00;
        end else begin
          led_d   = rom_hint;
          state_d = key_down ? StArm : StWaitKey;
        end
      end
      StArm: begin
        if (!key_down) state_d = StWaitKey;
      end
      StWaitKey: begin
        // A correct press beats a simultaneous timeout tick.
        if (key_down && (pressed == expected_q)) begin
          state_d = StHold;
          note_d  = expected_q;
        end else if (timeout) begin
          mistakes_d = mistakes_inc;
          advance    = 1'b1;
        end else if (key_down) begin
          mistakes_d = mistakes_inc;
          note_d     = 4'd0;
          state_d    = StRelease;
        end
      end
      StRelease: begin
        if (timeout) begin
          mistakes_d = mistakes_inc;
          advance    = 1'b1;
        end else if (!key_down) begin
          state_d = StWaitKey;
        end
      end
      StHold: begin
        if (!key_down) advance = 1'b1;
      end
      StRest: begin
        if (QUARTER_BEAT) advance = 1'b1;
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (advance) begin
      note_d = 4'd0;
      if (last_addr) begin
        state_d = StDone;
        led_d   = 8'h00;
      end else begin
        state_d = StFetch;
        addr_d  = addr_q + 1'b1;
      end
    end

    if (START) begin
      state_d    = StFetch;
      addr_d     = '0;
      mistakes_d = 8'd0;
      note_d     = 4'd0;
      led_d      = 8'h00;
    end

    busy_d = !(state_d inside {StIdle, StDone});
    done_d = (state_d == StDone);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      expected_q <= 4'd0;
      note_q     <= 4'd0;
      led_q      <= 8'h00;
      mistakes_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      expected_q <= expected_d;
      note_q     <= note_d;
      led_q      <= led_d;
      mistakes_q <= mistakes_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr = addr_q;
  assign note     = note_q;
  assign Led      = led_q;
  assign mistakes = mistakes_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/lesson_controller.md
# lesson_controller

Sequencer for the piano's lesson mode. Steps through a song stored in an external note ROM and presents each expected note on the LEDs. It waits for the player to press the matching key switch, counts mistakes, and skips notes on timeout. It produces the note code that drives the tone mux and 7-segment display, replacing the free-running lesson path when lesson mode is active.

## Interface
Parameters:
- ADDR_W, 6, width of the song ROM address (max song length 2^ADDR_W notes)
- TIMEOUT_BEATS, 8, QUARTER_BEAT ticks allowed per note before a skip (1..255)

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- START  in  1  one-cycle pulse; starts or restarts the lesson from address 0
- QUARTER_BEAT  in  1  one-cycle tick, synchronous to CLK
- sw  in  8  debounced key switches; sw[7]=C4 … sw[0]=C5
- rom_addr  out  ADDR_W  song ROM address (registered)
- rom_note  in  4  ROM data, valid one cycle after rom_addr changes
- note  out  4  note to tone generator/display; 0 = silent
- Led  out  8  one-hot hint of expected key (C4→Led[7] … C5→Led[0]); 0 when no hint
- mistakes  out  8  mistake count, saturates at 255
- busy  out  1  high from FETCH through last note
- done  out  1  high in DONE state

## Operation
- Note codes: 0 = rest, 1..8 = C4,D,E,F,G,A,B,C5, 15 = end marker, 9..14 treated as rest.
- Pressed note: priority-encode sw, highest index wins (sw[7]→1 … sw[0]→8); sw==0 → none.
- States: IDLE, FETCH, EVAL, ARM, WAIT_KEY, HOLD, RELEASE, REST, DONE.
- IDLE: all outputs 0. START → FETCH, rom_addr=0, mistakes=0.
- FETCH: wait one cycle for ROM data → EVAL.
- EVAL: latch rom_note as expected note.
  - 15 → DONE.
  - Rest code → REST.
  - Otherwise Led=hint. sw≠0 → ARM, else → WAIT_KEY.
- ARM: wait for sw==0 → WAIT_KEY. Prevents a held key from carrying over to the next note.
- WAIT_KEY:
  - Pressed == expected → HOLD, note=expected.
  - Pressed ≠ expected and not none → mistakes+1, → RELEASE.
- RELEASE: note=0. sw==0 → WAIT_KEY. The beat counter keeps running.
- HOLD: note=expected while sw≠0. sw==0 → advance.
- REST: note=0, Led=0. Next QUARTER_BEAT → advance.
- Advance:
  - rom_addr == 2^ADDR_W−1 → DONE.
  - Otherwise rom_addr+1 → FETCH.
- DONE: done=1, busy=0, note=0, Led=0. mistakes holds its value.
- START in any state restarts: clears mistakes, rom_addr=0, → FETCH. START overrides all simultaneous events.
- mistakes increments saturate at 255, never wrap.

## Timing
- Reset values: state IDLE; rom_addr, note, Led, mistakes = 0; busy = 0; done = 0. All outputs are registered.
- START sampled at edge n: FETCH at n+1 (rom_addr=0, busy=1), EVAL at n+2, Led valid at n+3.
- Correct press sampled at edge k in WAIT_KEY: note valid at k+1.
- Wrong press at edge k: mistakes updated at k+1.
- Key release in HOLD at edge k: note=0 and rom_addr+1 at k+1; next Led at k+3.
- Beat counter clears on entry to WAIT_KEY from EVAL/ARM and counts QUARTER_BEAT ticks in WAIT_KEY and RELEASE.
- Correct press and timeout tick in the same cycle: the correct press wins.

## Configuration
- LESSON_TIMEOUT_EN defined:
  - Reaching TIMEOUT_BEATS ticks in WAIT_KEY/RELEASE → mistakes+1, advance.
- LESSON_TIMEOUT_EN undefined:
  - No beat counter; the block waits indefinitely for the correct key.
  - QUARTER_BEAT is used only by REST.

## Test plan
- Reset mid-HOLD with note=3 → all outputs 0 immediately, state IDLE; no activity until START.
- ROM {1,5,15}, correct presses sw=8'h80 then sw=8'h08, each released → Led 8'h80 then 8'h08, note 1 then 5 while held, done=1, mistakes=0.
- ROM {3,15}, press sw=8'h01 then release, then sw=8'h20 → mistakes=1, note=0 during the wrong press, note=3 on the correct press.
- LESSON_TIMEOUT_EN, TIMEOUT_BEATS=2, ROM {2,4,15}, no presses → after the 2nd tick mistakes=1 and Led moves to 8'h10; after 4 ticks total, done=1, mistakes=2.
- ROM {1,0,1,15}, hold sw[7] continuously → first note plays; rest lasts exactly one QUARTER_BEAT; third note is not accepted until sw==0 (ARM), then accepted on re-press.
- 256 wrong presses → mistakes saturates at 255. START pulse → mistakes=0, rom_addr=0, busy=1.
